// File: rtl/fractal_pkg.sv
// Shared types and helpers for the fractal video path: FSM states,
// address-width helper and the solver-value to colour mapping.
package fractal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int MAP_W = 32;

  function automatic int fn_clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Word address width inside one solver memory (ceil of pixels / solvers).
  function automatic int fn_addr_w(input int w, input int h, input int n);
    return fn_clog2_min1((w * h + n - 1) / n);
  endfunction

  // mode 0: value replicated MSB-first across data_w bits.
  // mode 1: all-ones value maps to black, anything else to all-ones.
  function automatic logic [MAP_W-1:0] fn_colour_map(
    input logic [MAP_W-1:0] value,
    input int               iter_w,
    input int               data_w,
    input logic             mode
  );
    logic [MAP_W-1:0] res;
    logic [MAP_W-1:0] ones;
    logic [4:0]       di;
    logic [4:0]       si;
    res  = '0;
    ones = (MAP_W'(1) << iter_w) - MAP_W'(1);
    if (mode) begin
      if ((value & ones) != ones) begin
        res = (MAP_W'(1) << data_w) - MAP_W'(1);
      end
    end else begin
      for (int k = 0; k < MAP_W; k++) begin
        if (k < data_w) begin
          di      = 5'(data_w - 1 - k);
          si      = 5'(iter_w - 1 - (k % iter_w));
          res[di] = value[si];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; the head
// word reads as zero while empty. A push into a full FIFO is accepted only
// together with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
)(
  input  logic             clk,
  input  logic             srst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = !w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/stream_pixel_source.sv
// Raster-order pixel source: issues credit-gated reads to the interleaved
// solver memories, colour-maps the returns and streams them Avalon-ST style.
// Optional palette lookup: define STREAM_PIXEL_SOURCE_PALETTE_EN.
module stream_pixel_source
  import fractal_pkg::*;
#(
  parameter int FRAME_W      = 640,
  parameter int FRAME_H      = 480,
  parameter int NUM_SOLVERS  = 29,
  parameter int READ_LATENCY = 2,
  parameter int ITER_W       = 4,
  parameter int DATA_W       = 8
)(
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic                                                 continuous,
  input  logic                                                 mode,
  output logic [fn_clog2_min1(NUM_SOLVERS)-1:0]                rd_id,
  output logic [fn_addr_w(FRAME_W, FRAME_H, NUM_SOLVERS)-1:0]  rd_addr,
  output logic                                                 rd_en,
  input  logic [ITER_W-1:0]                                    rd_data,
`ifdef STREAM_PIXEL_SOURCE_PALETTE_EN
  input  logic                                                 pal_we,
  input  logic [ITER_W-1:0]                                    pal_addr,
  input  logic [DATA_W-1:0]                                    pal_wdata,
`endif
  input  logic                                                 src_ready,
  output logic                                                 src_valid,
  output logic                                                 src_sop,
  output logic                                                 src_eop,
  output logic [DATA_W-1:0]                                    src_data,
  output logic                                                 busy,
  output logic [15:0]                                          frame_count
);

  localparam int TOTAL  = FRAME_W * FRAME_H;
  localparam int ID_W   = fn_clog2_min1(NUM_SOLVERS);
  localparam int ADDR_W = fn_addr_w(FRAME_W, FRAME_H, NUM_SOLVERS);
  localparam int PIX_W  = fn_clog2_min1(TOTAL);
`ifdef STREAM_PIXEL_SOURCE_PALETTE_EN
  localparam int LOOKUP_STAGES = 1;
`else
  localparam int LOOKUP_STAGES = 0;
`endif
  localparam int FIFO_DEPTH = READ_LATENCY + 2 + LOOKUP_STAGES;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_W     = DATA_W + 2;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [PIX_W-1:0]        r_pix;
  logic [ID_W-1:0]         r_id;
  logic [ADDR_W-1:0]       r_addr;
  logic [READ_LATENCY-1:0] r_tag_v;
  logic [READ_LATENCY-1:0] r_tag_sop;
  logic [READ_LATENCY-1:0] r_tag_eop;
  logic [15:0]             r_frame_count;
  logic                    w_issue;
  logic                    w_last_pix;
  logic                    w_credit_ok;
  logic                    w_push;
  logic                    w_push_sop;
  logic                    w_push_eop;
  logic [DATA_W-1:0]       w_push_data;
  logic                    w_pop;
  logic                    w_fifo_valid;
  logic [FIFO_W-1:0]       w_fifo_out;
  logic [CNT_W-1:0]        w_fifo_count;
  logic [CNT_W-1:0]        w_in_flight;

`ifdef STREAM_PIXEL_SOURCE_PALETTE_EN
  logic [DATA_W-1:0]       r_pal [2**ITER_W];
  logic                    r_pipe_v;
  logic                    r_pipe_sop;
  logic                    r_pipe_eop;
  logic [ITER_W-1:0]       r_pipe_val;
`endif

  assign w_last_pix  = (r_pix == PIX_W'(TOTAL - 1));
  // Reads in flight plus FIFO occupancy never exceed the FIFO depth, so
  // every return always has a slot even with the sink stalled.
  assign w_credit_ok = (({1'b0, w_in_flight} + {1'b0, w_fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_issue = w_credit_ok;
        if (w_credit_ok && w_last_pix) begin
          w_state_next = continuous ? ST_ISSUE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((w_fifo_count == '0) && (w_in_flight == '0)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Pixel, solver-select and word-address counters advance together.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pix  <= '0;
      r_id   <= '0;
      r_addr <= '0;
    end else if (w_issue) begin
      if (w_last_pix) begin
        r_pix  <= '0;
        r_id   <= '0;
        r_addr <= '0;
      end else begin
        r_pix <= r_pix + PIX_W'(1);
        if (r_id == ID_W'(NUM_SOLVERS - 1)) begin
          r_id   <= '0;
          r_addr <= r_addr + ADDR_W'(1);
        end else begin
          r_id <= r_id + ID_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag_v   <= '0;
      r_tag_sop <= '0;
      r_tag_eop <= '0;
    end else begin
      r_tag_v[0]   <= w_issue;
      r_tag_sop[0] <= w_issue && (r_pix == '0);
      r_tag_eop[0] <= w_issue && w_last_pix;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_sop[i] <= r_tag_sop[i-1];
        r_tag_eop[i] <= r_tag_eop[i-1];
      end
    end
  end

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_in_flight = w_in_flight + CNT_W'(r_tag_v[i]);
    end
`ifdef STREAM_PIXEL_SOURCE_PALETTE_EN
    w_in_flight = w_in_flight + CNT_W'(r_pipe_v);
`endif
  end

`ifdef STREAM_PIXEL_SOURCE_PALETTE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2**ITER_W; i++) begin
        r_pal[i] <= '0;
      end
    end else if (pal_we) begin
      r_pal[pal_addr] <= pal_wdata;
    end
  end

  // Extra stage so the palette read sits in its own cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pipe_v   <= 1'b0;
      r_pipe_sop <= 1'b0;
      r_pipe_eop <= 1'b0;
      r_pipe_val <= '0;
    end else begin
      r_pipe_v   <= r_tag_v[READ_LATENCY-1];
      r_pipe_sop <= r_tag_sop[READ_LATENCY-1];
      r_pipe_eop <= r_tag_eop[READ_LATENCY-1];
      r_pipe_val <= rd_data;
    end
  end

  assign w_push      = r_pipe_v;
  assign w_push_sop  = r_pipe_sop;
  assign w_push_eop  = r_pipe_eop;
  assign w_push_data = mode ? r_pal[r_pipe_val]
                            : DATA_W'(fn_colour_map(MAP_W'(r_pipe_val), ITER_W, DATA_W, 1'b0));
`else
  assign w_push      = r_tag_v[READ_LATENCY-1];
  assign w_push_sop  = r_tag_sop[READ_LATENCY-1];
  assign w_push_eop  = r_tag_eop[READ_LATENCY-1];
  assign w_push_data = DATA_W'(fn_colour_map(MAP_W'(rd_data), ITER_W, DATA_W, mode));
`endif

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clock),
    .srst    (reset),
    .i_push  (w_push),
    .i_data  ({w_push_sop, w_push_eop, w_push_data}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign w_pop = w_fifo_valid && src_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_frame_count <= '0;
    end else if (w_pop && w_fifo_out[FIFO_W-2]) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign rd_en       = w_issue;
  assign rd_id       = r_id;
  assign rd_addr     = r_addr;
  assign src_valid   = w_fifo_valid;
  assign src_sop     = w_fifo_out[FIFO_W-1];
  assign src_eop     = w_fifo_out[FIFO_W-2];
  assign src_data    = w_fifo_out[DATA_W-1:0];
  assign busy        = (r_state != ST_IDLE) || w_fifo_valid;
  assign frame_count = r_frame_count;

endmodule
